// File: rtl/serial_sub_arbiter_if.sv
// Requester and serial-subtractor signal bundle for serial_sub_arbiter.
// The master side is the requester/subtractor environment; the slave side is the arbiter.
interface serial_sub_arbiter_if;
    logic [3:0]   req;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   gnt;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_diff;
    logic         rsp_bout;
    logic         rsp_err;
    logic         busy;
    logic         sub_start;
    logic [31:0]  sub_a;
    logic [31:0]  sub_b;
    logic         sub_bin;
    logic [31:0]  sub_diff;
    logic         sub_bout;
    logic         sub_done;

    modport master (
        output req, req_a, req_b, sub_diff, sub_bout, sub_done,
        input  gnt, rsp_valid, rsp_diff, rsp_bout, rsp_err, busy,
        input  sub_start, sub_a, sub_b, sub_bin
    );

    modport slave (
        input  req, req_a, req_b, sub_diff, sub_bout, sub_done,
        output gnt, rsp_valid, rsp_diff, rsp_bout, rsp_err, busy,
        output sub_start, sub_a, sub_b, sub_bin
    );
endinterface

// File: rtl/serial_sub_arbiter.sv
// Round-robin arbiter sharing one serial subtractor among four requesters.
// All outputs are registered; each output register is loaded with its next-state value.
module serial_sub_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_sub_arbiter_if.slave  s_if
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_idx;
    logic [1:0]         r_last_idx;
    logic [TW-1:0]      r_timer;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [31:0]        r_rsp_diff;
    logic               r_rsp_bout;
    logic               r_rsp_err;
    logic               r_busy;
    logic               r_sub_start;
    logic [31:0]        r_sub_a;
    logic [31:0]        r_sub_b;

    logic [1:0]         w_idx;
    logic [1:0]         w_last_idx;
    logic [1:0]         w_pick;
    logic [TW-1:0]      w_timer;
    logic [N_REQ-1:0]   w_gnt;
    logic [N_REQ-1:0]   w_rsp_valid;
    logic [31:0]        w_rsp_diff;
    logic               w_rsp_bout;
    logic               w_rsp_err;
    logic               w_busy;
    logic               w_sub_start;
    logic [31:0]        w_sub_a;
    logic [31:0]        w_sub_b;
    logic               w_any_req;
    logic               w_done_ok;
    logic               w_timeout;

    // First set bit scanning upward from last+1, wrapping.
    function automatic logic [1:0] rr_pick(
        input logic [3:0] r,
        input logic [1:0] last
    );
        logic [1:0] c;
        rr_pick = last + 2'd1;
        for (int k = 3; k >= 0; k--) begin
            c = last + 2'(k + 1);
            if (r[c]) rr_pick = c;
        end
    endfunction

    assign w_any_req = (s_if.req != 4'b0000);
    assign w_pick    = rr_pick(s_if.req, r_last_idx);
    // Timer is zero only in the first WAIT cycle, where a stale done is ignored.
    assign w_done_ok = s_if.sub_done && (r_timer != '0);
    assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_last_idx  <= 2'd3;
            r_timer     <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_diff  <= '0;
            r_rsp_bout  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_sub_start <= 1'b0;
            r_sub_a     <= '0;
            r_sub_b     <= '0;
        end else begin
            r_state     <= w_next;
            r_idx       <= w_idx;
            r_last_idx  <= w_last_idx;
            r_timer     <= w_timer;
            r_gnt       <= w_gnt;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_diff  <= w_rsp_diff;
            r_rsp_bout  <= w_rsp_bout;
            r_rsp_err   <= w_rsp_err;
            r_busy      <= w_busy;
            r_sub_start <= w_sub_start;
            r_sub_a     <= w_sub_a;
            r_sub_b     <= w_sub_b;
        end
    end

    always_comb begin
        w_next = IDLE;
        unique case (r_state)
            IDLE:    w_next = w_any_req ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = (w_done_ok || w_timeout) ? RESP : WAIT;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_idx       = r_idx;
        w_last_idx  = r_last_idx;
        w_timer     = r_timer;
        w_gnt       = '0;
        w_rsp_valid = '0;
        w_rsp_diff  = r_rsp_diff;
        w_rsp_bout  = r_rsp_bout;
        w_rsp_err   = r_rsp_err;
        w_busy      = (w_next != IDLE);
        w_sub_start = 1'b0;
        w_sub_a     = r_sub_a;
        w_sub_b     = r_sub_b;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_idx       = w_pick;
                    w_gnt       = N_REQ'(1) << w_pick;
                    w_sub_start = 1'b1;
                    w_sub_a     = s_if.req_a[{w_pick, 5'd0} +: 32];
                    w_sub_b     = s_if.req_b[{w_pick, 5'd0} +: 32];
                    w_timer     = '0;
                end
            end
            ISSUE: w_timer = '0;
            WAIT: begin
                if (w_done_ok) begin
                    w_rsp_diff  = s_if.sub_diff;
                    w_rsp_bout  = s_if.sub_bout;
                    w_rsp_err   = 1'b0;
                    w_rsp_valid = N_REQ'(1) << r_idx;
                end else if (w_timeout) begin
                    w_rsp_diff  = '0;
                    w_rsp_bout  = 1'b0;
                    w_rsp_err   = 1'b1;
                    w_rsp_valid = N_REQ'(1) << r_idx;
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            RESP: w_last_idx = r_idx;
            default: ;
        endcase
    end

    assign s_if.gnt       = r_gnt;
    assign s_if.rsp_valid = r_rsp_valid;
    assign s_if.rsp_diff  = r_rsp_diff;
    assign s_if.rsp_bout  = r_rsp_bout;
    assign s_if.rsp_err   = r_rsp_err;
    assign s_if.busy      = r_busy;
    assign s_if.sub_start = r_sub_start;
    assign s_if.sub_a     = r_sub_a;
    assign s_if.sub_b     = r_sub_b;
    assign s_if.sub_bin   = 1'b0;

endmodule
